// File: rtl/key_load_sequencer.sv
// key_load_sequencer
//   Serially receives a key word and its popcount check word from a key
//   store, verifies the check and only then applies the key to the
//   mux-select (D_x) inputs of a locked core. The core sees the all-zero
//   key until a checked key has been applied, and again after any check
//   failure, clear or reset.
//
// Handshake: a beat happens on a rising edge where in_valid & in_ready are
//   both high. in_ready is a pure decode of state, so it never depends on
//   in_valid. The store may hold in_valid low for any number of cycles;
//   the sequence simply waits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a load when idle
//   clear      one-cycle pulse, zeroes the key and returns to idle (top priority)
//   in_valid   key store presents in_bit
//   in_bit     serial key bits (bit 0 first) followed by check bits (LSB first)
//   in_ready   sequencer accepts in_bit this cycle (LOAD or CHECK)
//   key_out    applied key, D_0 = bit 0
//   key_valid  key_out holds a checked key
//   busy       sequence in progress (LOAD or CHECK)
//   err        sticky check failure, cleared by start, clear or reset
//   dbg_state  current FSM state for observation
module key_load_sequencer #(
  parameter int KEY_BITS = 6,
  parameter int CHK_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic                in_valid,
  input  logic                in_bit,
  output logic                in_ready,
  output logic [KEY_BITS-1:0] key_out,
  output logic                key_valid,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  // One counter serves both the key phase and the check phase.
  localparam int CNT_MAX = (KEY_BITS > CHK_BITS) ? KEY_BITS : CHK_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [KEY_BITS-1:0] r_shadow;
  logic [CHK_BITS-1:0] r_check;
  logic [KEY_BITS-1:0] r_key_out;
  logic                r_key_valid;
  logic                r_err;

  logic                w_in_ready;
  logic                w_busy;
  logic                w_beat;
  logic                w_last_key;
  logic                w_last_chk;
  logic [CHK_BITS-1:0] w_pop;

  assign w_beat     = in_valid & w_in_ready;
  assign w_last_key = (r_cnt == CNT_W'(KEY_BITS - 1));
  assign w_last_chk = (r_cnt == CNT_W'(CHK_BITS - 1));

  // Popcount of the whole shadow register; it always fits in CHK_BITS
  // because 2^CHK_BITS > KEY_BITS.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KEY_BITS; i++) begin
      w_pop = w_pop + CHK_BITS'(r_shadow[i]);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_beat && w_last_key) w_next_state = S_CHECK;
      end
      S_CHECK: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_beat && w_last_chk) w_next_state = S_APPLY;
      end
      S_APPLY: begin
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // clear wins over start, beats and APPLY in the same cycle
    if (clear) w_next_state = S_IDLE;
  end

  // Datapath: shadow/check capture and the atomic key transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_check     <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_check     <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // key_out/key_valid are left alone so an old good key stays
          // applied while a new one is being loaded.
          if (start) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_check  <= '0;
            r_err    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_shadow[r_cnt] <= in_bit;
            r_cnt           <= w_last_key ? '0 : r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_beat) begin
            // Shift in from the top so the first check bit ends at bit 0.
            r_check <= {in_bit, r_check[CHK_BITS-1:1]};
            r_cnt   <= w_last_chk ? '0 : r_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          if (r_check == w_pop) begin
            r_key_out   <= r_shadow;
            r_key_valid <= 1'b1;
          end else begin
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_key_load_sequencer.sv
// Bench for key_load_sequencer: directed vectors, a queue-level reference
// model checked every cycle, plus literal expectations at key points.
module tb_key_load_sequencer;

  localparam int KEY_BITS = 6;
  localparam int CHK_BITS = 4;
  localparam int NB       = KEY_BITS + CHK_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start = 1'b0;
  logic                clear = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_bit = 1'b0;
  logic                in_ready;
  logic [KEY_BITS-1:0] key_out;
  logic                key_valid;
  logic                busy;
  logic                err;
  logic [1:0]          dbg_state;

  key_load_sequencer #(.KEY_BITS(KEY_BITS), .CHK_BITS(CHK_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks the sequence as "collecting NB bits" then "one apply cycle";
  // the received stream is kept as a plain queue.
  logic                m_collecting;
  logic                m_apply_next;
  logic                m_bits[$];
  logic [KEY_BITS-1:0] m_key;
  logic                m_key_valid;
  logic                m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collecting = 1'b0;
      m_apply_next = 1'b0;
      m_bits.delete();
      m_key        = '0;
      m_key_valid  = 1'b0;
      m_err        = 1'b0;
    end else if (clear) begin
      m_collecting = 1'b0;
      m_apply_next = 1'b0;
      m_bits.delete();
      m_key        = '0;
      m_key_valid  = 1'b0;
      m_err        = 1'b0;
    end else if (m_apply_next) begin
      logic [KEY_BITS-1:0] k;
      logic [CHK_BITS-1:0] c;
      for (int i = 0; i < KEY_BITS; i++) k[i] = m_bits[i];
      for (int j = 0; j < CHK_BITS; j++) c[j] = m_bits[KEY_BITS + j];
      if (int'(c) == $countones(k)) begin
        m_key       = k;
        m_key_valid = 1'b1;
      end else begin
        m_key       = '0;
        m_key_valid = 1'b0;
        m_err       = 1'b1;
      end
      m_apply_next = 1'b0;
    end else if (m_collecting) begin
      if (in_valid) m_bits.push_back(in_bit);
      if (m_bits.size() == NB) begin
        m_collecting = 1'b0;
        m_apply_next = 1'b1;
      end
    end else if (start) begin
      m_collecting = 1'b1;
      m_bits.delete();
      m_err        = 1'b0;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("in_ready",  in_ready,  m_collecting);
    check("busy",      busy,      m_collecting);
    check("key_out",   key_out,   m_key);
    check("key_valid", key_valid, m_key_valid);
    check("err",       err,       m_err);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send n bits of word, LSB first; gap inserts two idle cycles between beats.
  task automatic send_bits(input logic [15:0] word, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = word[i];
      tick();
      if (gap && i < n - 1) begin
        in_valid = 1'b0;
        tick();
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // key 0b001101 with check 3 / check 4, key 0b110010 with check 3
  localparam logic [15:0] W_GOOD  = 16'd13 | (16'd3 << KEY_BITS);
  localparam logic [15:0] W_BAD   = 16'd13 | (16'd4 << KEY_BITS);
  localparam logic [15:0] W_GOOD2 = 16'd50 | (16'd3 << KEY_BITS);

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle in_ready", in_ready, 1'b0);
      check("idle key_out", key_out, '0);
    end

    // good key, in_valid held high: key appears 11 edges after start edge
    do_start();                       // start edge t
    check("start busy", busy, 1'b1);
    send_bits(W_GOOD, NB, 1'b0);      // last beat at t+10
    check("pre-apply key_valid", key_valid, 1'b0);
    check("apply busy", busy, 1'b0);
    tick();                           // t+11
    check("good key_out", key_out, 6'b001101);
    check("good key_valid", key_valid, 1'b1);
    check("good err", err, 1'b0);

    // bad check word over a valid key: key held during load, dropped at APPLY
    do_start();
    send_bits(W_BAD, NB - 1, 1'b0);
    check("held key_out", key_out, 6'b001101);
    send_bits(W_BAD >> (NB - 1), 1, 1'b0);
    tick();
    check("bad key_out", key_out, 6'b000000);
    check("bad key_valid", key_valid, 1'b0);
    check("bad err", err, 1'b1);

    // next start clears err, good key reloads
    do_start();
    check("err cleared by start", err, 1'b0);
    send_bits(W_GOOD, NB, 1'b0);
    tick();
    check("reload key_out", key_out, 6'b001101);

    // gapped in_valid
    do_start();
    send_bits(W_GOOD2, NB, 1'b1);
    tick();
    check("gap key_out", key_out, 6'b110010);
    check("gap key_valid", key_valid, 1'b1);

    // clear mid-LOAD after 3 beats
    do_start();
    send_bits(W_GOOD, 3, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear busy", busy, 1'b0);
    check("clear key_out", key_out, 6'b000000);
    check("clear key_valid", key_valid, 1'b0);

    // start and clear together in IDLE: start ignored
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("start+clear busy", busy, 1'b0);
    check("start+clear in_ready", in_ready, 1'b0);
    tick();
    check("start+clear busy later", busy, 1'b0);

    // asynchronous reset in CHECK, after a valid key was applied
    do_start();
    send_bits(W_GOOD, NB, 1'b0);
    tick();
    check("pre-reset key_valid", key_valid, 1'b1);
    do_start();
    send_bits(W_BAD, KEY_BITS + 2, 1'b0);
    check("in check busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst key_out", key_out, 6'b000000);
    check("async rst key_valid", key_valid, 1'b0);
    check("async rst busy", busy, 1'b0);
    check("async rst in_ready", in_ready, 1'b0);
    check("async rst err", err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-reset busy", busy, 1'b0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_load_sequencer.md
# key_load_sequencer

Serially loads, checks and applies the key word that drives the mux-select inputs (D_x pairs) of a mux-locked netlist. Key bits arrive one per handshake from a key store; once a full key and its check word are received, the popcount check is verified. Only then is the key transferred atomically to the locked core's key inputs. Until a key has been accepted, and after any failure or clear, the core sees the all-zero key.

## Interface
- KEY_BITS, 6, number of key bits (two per locking mux); must be ≥ 2
- CHK_BITS, 4, width of the check word; must satisfy 2^CHK_BITS > KEY_BITS
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load sequence when in IDLE, ignored otherwise
- clear  in  1  one-cycle pulse; returns key_out to zero and FSM to IDLE from any state
- in_valid  in  1  key store presents in_bit
- in_bit  in  1  serial key/check bit, LSB first
- in_ready  out  1  sequencer accepts in_bit this cycle
- key_out  out  KEY_BITS  applied key to the core (D_0 = bit 0)
- key_valid  out  1  key_out holds a checked key
- busy  out  1  sequence in progress (LOAD or CHECK)
- err  out  1  sticky check failure, cleared by start, clear or reset

## Operation
- States: IDLE, LOAD, CHECK, APPLY.
- IDLE: in_ready=0. On start: clear shift register and counter, clear err, go to LOAD. key_out and key_valid keep their previous values.
- LOAD: in_ready=1. Each beat (in_valid & in_ready) shifts in_bit into the shadow register at index cnt, and cnt increments. Bit index 0 is received first. After beat KEY_BITS-1, reset cnt to 0 and go to CHECK.
- CHECK: in_ready=1. Each beat shifts in_bit into the check register, LSB first. After beat CHK_BITS-1, go to APPLY.
- APPLY, one cycle, in_ready=0:
  - If check == popcount(shadow): key_out<=shadow, key_valid<=1.
  - Otherwise: key_out<=0, key_valid<=0, err<=1.
  - In both cases go to IDLE.
- The popcount is computed over the full shadow register, zero-extended to CHK_BITS. The comparison is unsigned.
- clear has priority over every other event in the same cycle. Its effect on the next edge: key_out=0, key_valid=0, err=0, state=IDLE, cnt=0, shadow=0.
- start arriving in LOAD, CHECK or APPLY is ignored.
- A new start after a valid key keeps the old key_out and key_valid until the new APPLY. If the new key fails, key_out drops to 0.
- Gaps in in_valid stall the sequence indefinitely; no timeout.
- in_valid during IDLE or APPLY is not consumed.
- Reset mid-sequence aborts it with no partial key applied.

## Timing
- Reset values: key_out=0, key_valid=0, err=0, busy=0, in_ready=0, state=IDLE.
- All outputs are registered except in_ready and busy, which are decoded directly from state (combinational).
- start sampled at edge t gives busy=1 and in_ready=1 from t+1.
- With in_valid held high, the last check beat is accepted at edge t+KEY_BITS+CHK_BITS.
- key_out, key_valid and err update at the following edge (APPLY), i.e. t+KEY_BITS+CHK_BITS+1, with busy=0 in that cycle.
- Minimum sequence for the defaults: 11 cycles from start to key_valid.
- key_out never shows a partially loaded value; it changes only at APPLY, on clear, or on reset.

## Test plan
- Reset, then idle 5 cycles -> key_out=0, key_valid=0, err=0, in_ready=0 throughout.
- start, then stream key bits 1,0,1,1,0,0 (key 0b001101) and check bits 1,1,0,0 (3), in_valid held high -> key_out=6'b001101 and key_valid=1 exactly 11 cycles after start; err=0.
- Same key with check word 4 -> key_out=0, key_valid=0, err=1 after APPLY. A following good sequence clears err at start.
- Valid key 0b001101 loaded, then start with a bad check -> key_out stays 0b001101 during LOAD/CHECK and drops to 0 at APPLY.
- in_valid toggling 1,0,0,1,... during LOAD -> beats are counted only when in_valid=1; the final key matches the stream.
- clear asserted mid-LOAD (after 3 beats), plus start and clear together in IDLE -> state IDLE, busy=0, key_out=0, key_valid=0. start is ignored in the coincident cycle.
- rst_n asserted asynchronously mid-CHECK -> all outputs return to reset values immediately, with no clock edge required.
